// File: rtl/discharge_pulse_if.sv
// Signal bundle between the waveform/key control logic, the breakdown detector
// and the discharge pulse sequencer.
interface discharge_pulse_if;
  // There is no valid/ready handshake. Every input is a level that is sampled on
  // each rising clk edge. The one exception is single_discharge_button_pressed,
  // which is a one-cycle pulse and is only honoured while current_state is idle.
  // Every output is registered and changes only on the clk edge, except during an
  // asynchronous reset.
  logic [15:0] waveform;
  logic [15:0] on_time;
  logic [15:0] deion_time;
  logic        single_discharge_button_pressed;
  logic        is_breakdown;

  logic [7:0]  current_state;
  logic [31:0] timer_wait_breakdown;
  logic        gate_main;
  logic        gate_buck_a;
  logic        gate_buck_b;
  logic        open_timeout;
  logic [31:0] pulse_count;

  modport master (
    output waveform, on_time, deion_time, single_discharge_button_pressed, is_breakdown,
    input  current_state, timer_wait_breakdown, gate_main, gate_buck_a, gate_buck_b,
           open_timeout, pulse_count
  );

  modport slave (
    input  waveform, on_time, deion_time, single_discharge_button_pressed, is_breakdown,
    output current_state, timer_wait_breakdown, gate_main, gate_buck_a, gate_buck_b,
           open_timeout, pulse_count
  );
endinterface

// File: rtl/discharge_pulse_fsm.sv
// EDM discharge cycle sequencer: waits for gap breakdown, runs a buck-interleaved
// or resistor discharge, then deionizes. Drives the power-stage gate enables.
module discharge_pulse_fsm #(
  parameter logic [31:0] WAIT_TIMEOUT     = 32'd100000,
  parameter logic [15:0] BUCK_HALF_PERIOD = 16'd50,
  parameter logic [15:0] DEAD_TIME        = 16'd5
) (
  input logic              clk,
  input logic              rst_n,
  discharge_pulse_if.slave bus
);

  typedef enum logic [7:0] {
    S_IDLE              = 8'b01000000,
    S_WAIT_BREAKDOWN    = 8'b00000001,
    S_BUCK_INTERLEAVE   = 8'b00000010,
    S_RES_DISCHARGE     = 8'b00000100,
    S_DEION             = 8'b10000000,
    S_DEION_SINGLE_BUCK = 8'b00000000
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] half_q, half_d;
  logic        phase_q, phase_d;
  logic [15:0] on_time_q, on_time_d;
  logic [15:0] deion_time_q, deion_time_d;
  logic        buck_q, buck_d;
  logic        single_q, single_d;
  logic        gate_main_q, gate_main_d;
  logic        gate_a_q, gate_a_d;
  logic        gate_b_q, gate_b_d;
  logic        open_timeout_q, open_timeout_d;
  logic [31:0] pulse_count_q, pulse_count_d;

  logic        wf_en;
  logic        wf_single;
  logic [15:0] on_len;
  logic [15:0] deion_len;
  logic        on_done;
  logic        deion_done;
  logic        buck_on;
  logic        unused_waveform;

  assign wf_en           = bus.waveform[13];
  assign wf_single       = bus.waveform[14];
  assign unused_waveform = ^bus.waveform[12:0];

  // A zero duration still occupies its state for one cycle.
  assign on_len     = (on_time_q == 16'd0) ? 16'd1 : on_time_q;
  assign deion_len  = (deion_time_q == 16'd0) ? 16'd1 : deion_time_q;
  assign on_done    = (cnt_q == on_len - 16'd1);
  assign deion_done = (cnt_q == deion_len - 16'd1);

  always_comb begin
    state_d        = state_q;
    pulse_count_d  = pulse_count_q;
    open_timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wf_en && (!wf_single || bus.single_discharge_button_pressed)) begin
          state_d = S_WAIT_BREAKDOWN;
        end
      end
      S_WAIT_BREAKDOWN: begin
        // Breakdown has priority over a timeout that expires on the same cycle.
        if (bus.is_breakdown) begin
          pulse_count_d = pulse_count_q + 32'd1;
          state_d       = buck_q ? S_BUCK_INTERLEAVE : S_RES_DISCHARGE;
        end else if (timer_q == WAIT_TIMEOUT) begin
          open_timeout_d = 1'b1;
          state_d        = single_q ? S_DEION_SINGLE_BUCK : S_DEION;
        end
      end
      S_BUCK_INTERLEAVE, S_RES_DISCHARGE: begin
        if (on_done) begin
          state_d = single_q ? S_DEION_SINGLE_BUCK : S_DEION;
        end
      end
      S_DEION: begin
        if (deion_done) begin
          state_d = (wf_en && !wf_single) ? S_WAIT_BREAKDOWN : S_IDLE;
        end
      end
      S_DEION_SINGLE_BUCK: begin
        if (deion_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && !wf_en) begin
      state_d        = S_IDLE;
      pulse_count_d  = pulse_count_q;
      open_timeout_d = 1'b0;
    end
  end

  always_comb begin
    on_time_d    = on_time_q;
    deion_time_d = deion_time_q;
    buck_d       = buck_q;
    single_d     = single_q;
    if (state_d == S_WAIT_BREAKDOWN && state_q != S_WAIT_BREAKDOWN) begin
      on_time_d    = bus.on_time;
      deion_time_d = bus.deion_time;
      buck_d       = bus.waveform[15];
      single_d     = bus.waveform[14];
    end

    timer_d = 32'd0;
    if (state_q == S_WAIT_BREAKDOWN && state_d == S_WAIT_BREAKDOWN) begin
      timer_d = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
    end

    cnt_d = 16'd0;
    if (state_d == state_q && state_q != S_IDLE && state_q != S_WAIT_BREAKDOWN) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Gate enables are decoded for the cycle about to start, so they switch on the
  // same edge as current_state.
  always_comb begin
    half_d  = half_q;
    phase_d = phase_q;
    buck_on = (state_d == S_BUCK_INTERLEAVE) && (cnt_d >= DEAD_TIME);
    if (buck_on) begin
      if (cnt_d == DEAD_TIME) begin
        half_d  = 16'd0;
        phase_d = 1'b0;
      end else if (half_q == BUCK_HALF_PERIOD - 16'd1) begin
        half_d  = 16'd0;
        phase_d = ~phase_q;
      end else begin
        half_d = half_q + 16'd1;
      end
    end
    gate_a_d    = buck_on && !phase_d;
    gate_b_d    = buck_on && phase_d;
    gate_main_d = (state_d == S_WAIT_BREAKDOWN) || (state_d == S_RES_DISCHARGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      timer_q        <= 32'd0;
      cnt_q          <= 16'd0;
      half_q         <= 16'd0;
      phase_q        <= 1'b0;
      on_time_q      <= 16'd0;
      deion_time_q   <= 16'd0;
      buck_q         <= 1'b0;
      single_q       <= 1'b0;
      gate_main_q    <= 1'b0;
      gate_a_q       <= 1'b0;
      gate_b_q       <= 1'b0;
      open_timeout_q <= 1'b0;
      pulse_count_q  <= 32'd0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      cnt_q          <= cnt_d;
      half_q         <= half_d;
      phase_q        <= phase_d;
      on_time_q      <= on_time_d;
      deion_time_q   <= deion_time_d;
      buck_q         <= buck_d;
      single_q       <= single_d;
      gate_main_q    <= gate_main_d;
      gate_a_q       <= gate_a_d;
      gate_b_q       <= gate_b_d;
      open_timeout_q <= open_timeout_d;
      pulse_count_q  <= pulse_count_d;
    end
  end

  assign bus.current_state        = state_q;
  assign bus.timer_wait_breakdown = timer_q;
  assign bus.gate_main            = gate_main_q;
  assign bus.gate_buck_a          = gate_a_q;
  assign bus.gate_buck_b          = gate_b_q;
  assign bus.open_timeout         = open_timeout_q;
  assign bus.pulse_count          = pulse_count_q;

endmodule

// File: tb/tb_discharge_pulse_fsm.sv
// Bench for discharge_pulse_fsm: pulse-level scenarios are expanded into per-cycle
// stimulus and expected-output queues, then replayed against the DUT.
module tb_discharge_pulse_fsm;
  localparam int WAIT_TO = 600;
  localparam int HALF    = 50;
  localparam int DEAD    = 5;

  localparam logic [7:0] S_IDLE  = 8'b01000000;
  localparam logic [7:0] S_WAIT  = 8'b00000001;
  localparam logic [7:0] S_BUCK  = 8'b00000010;
  localparam logic [7:0] S_RES   = 8'b00000100;
  localparam logic [7:0] S_DEION = 8'b10000000;
  localparam logic [7:0] S_DSB   = 8'b00000000;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  discharge_pulse_if bus();

  discharge_pulse_fsm #(
    .WAIT_TIMEOUT    (32'(WAIT_TO)),
    .BUCK_HALF_PERIOD(16'(HALF)),
    .DEAD_TIME       (16'(DEAD))
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [15:0] wf;
    logic [15:0] on_t;
    logic [15:0] dt_t;
    logic        btn;
    logic        bd;
  } stim_t;

  typedef struct packed {
    logic [7:0]  st;
    logic [31:0] tmr;
    logic        gm;
    logic        ga;
    logic        gb;
    logic        to;
    logic [31:0] pc;
  } exp_t;

  // Scoreboard
  stim_t       stim_q[$];
  exp_t        exp_q[$];
  logic [31:0] model_pc;
  int          bd_plan[4];
  int          tests_run = 0;
  int          fail_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      if (fail_count <= 20)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] noise_wf();
    logic [15:0] w;
    w     = 16'($urandom);
    w[13] = 1'b1;
    return w;
  endfunction

  function automatic logic [15:0] r16();
    return 16'($urandom);
  endfunction

  function automatic logic rbit(input int unsigned pct);
    return 1'($urandom_range(99, 0) < pct);
  endfunction

  // {a, b} during discharge cycle k of a buck pulse.
  function automatic logic [1:0] buck_ab(input int k);
    if (k < DEAD) return 2'b00;
    return (((k - DEAD) / HALF) % 2 == 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic push(input logic [15:0] wf, input logic [15:0] on_v, input logic [15:0] dt_v,
                      input logic btn, input logic bd, input logic [7:0] st, input int tmr,
                      input logic gm, input logic ga, input logic gb, input logic to);
    stim_t s;
    exp_t  e;
    s = '{wf, on_v, dt_v, btn, bd};
    e = '{st, 32'(tmr), gm, ga, gb, to, model_pc};
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Expand one pulse train starting and ending in idle; bd_plan[p] is the wait
  // cycle index of the breakdown for pulse p, beyond WAIT_TO meaning none.
  task automatic build(input logic buck, input logic single, input logic [15:0] on_v,
                       input logic [15:0] dt_v, input int npulses, input int abort_k);
    logic [15:0] wf_run;
    logic [15:0] w;
    logic [7:0]  dis_st;
    logic [7:0]  dei_st;
    logic [1:0]  ab;
    int          on_len;
    int          dt_len;
    int          wait_len;
    logic        hit;
    wf_run = {buck, single, 1'b1, 13'd0};
    on_len = (on_v == 16'd0) ? 1 : int'(on_v);
    dt_len = (dt_v == 16'd0) ? 1 : int'(dt_v);
    dis_st = buck ? S_BUCK : S_RES;
    dei_st = single ? S_DSB : S_DEION;
    push(wf_run, on_v, dt_v, single ? 1'b1 : rbit(50), rbit(50), S_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < npulses; p++) begin
      hit      = 1'(bd_plan[p] <= WAIT_TO);
      wait_len = (hit ? bd_plan[p] : WAIT_TO) + 1;
      for (int i = 0; i < wait_len; i++)
        push(noise_wf(), r16(), r16(), rbit(25), 1'(hit && i == wait_len - 1), S_WAIT, i,
             1'b1, 1'b0, 1'b0, 1'b0);
      if (hit) begin
        model_pc = model_pc + 32'd1;
        for (int k = 0; k < on_len; k++) begin
          ab = buck ? buck_ab(k) : 2'b00;
          if (p == 0 && k == abort_k) begin
            w     = noise_wf();
            w[13] = 1'b0;
            push(w, r16(), r16(), rbit(25), rbit(50), dis_st, 0, !buck, ab[1], ab[0], 1'b0);
            push(16'h0, r16(), r16(), 1'b0, rbit(50), S_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
          end
          push(noise_wf(), r16(), r16(), rbit(25), rbit(50), dis_st, 0, !buck, ab[1], ab[0], 1'b0);
        end
      end
      for (int k = 0; k < dt_len; k++) begin
        if (k == dt_len - 1 && !single) begin
          w = wf_run;
          if (p == npulses - 1) w[13] = 1'b0;
          push(w, on_v, dt_v, rbit(25), rbit(50), dei_st, 0, 1'b0, 1'b0, 1'b0, 1'(!hit && k == 0));
        end else begin
          push(noise_wf(), r16(), r16(), rbit(25), rbit(50), dei_st, 0, 1'b0, 1'b0, 1'b0,
               1'(!hit && k == 0));
        end
      end
    end
    if (single)
      repeat (3) push(wf_run, r16(), r16(), 1'b0, rbit(50), S_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(16'h0, r16(), r16(), 1'b0, rbit(50), S_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Driver: compare the cycle's outputs at the falling edge, then apply its inputs.
  task automatic run_queued();
    stim_t s;
    exp_t  e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      check_eq("state", 32'(bus.current_state), 32'(e.st));
      check_eq("timer", bus.timer_wait_breakdown, e.tmr);
      check_eq("gate_main", 32'(bus.gate_main), 32'(e.gm));
      check_eq("gate_buck_a", 32'(bus.gate_buck_a), 32'(e.ga));
      check_eq("gate_buck_b", 32'(bus.gate_buck_b), 32'(e.gb));
      check_eq("buck_excl", 32'(bus.gate_buck_a & bus.gate_buck_b), 32'd0);
      check_eq("open_timeout", 32'(bus.open_timeout), 32'(e.to));
      check_eq("pulse_count", bus.pulse_count, e.pc);
      bus.waveform                        = s.wf;
      bus.on_time                         = s.on_t;
      bus.deion_time                      = s.dt_t;
      bus.single_discharge_button_pressed = s.btn;
      bus.is_breakdown                    = s.bd;
    end
  endtask

  task automatic check_reset_values(input string phase);
    check_eq({phase, "_state"}, 32'(bus.current_state), 32'(S_IDLE));
    check_eq({phase, "_timer"}, bus.timer_wait_breakdown, 32'd0);
    check_eq({phase, "_gates"}, 32'({bus.gate_main, bus.gate_buck_a, bus.gate_buck_b}), 32'd0);
    check_eq({phase, "_open_timeout"}, 32'(bus.open_timeout), 32'd0);
    check_eq({phase, "_pulse_count"}, bus.pulse_count, 32'd0);
  endtask

  initial begin
    logic       bk;
    logic       sg;
    int         np;
    int         r;
    int         abk;
    logic [15:0] onv;
    logic [15:0] dtv;

    bus.waveform                        = 16'h0;
    bus.on_time                         = 16'h0;
    bus.deion_time                      = 16'h0;
    bus.single_discharge_button_pressed = 1'b0;
    bus.is_breakdown                    = 1'b0;
    model_pc                            = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Continuous resistor pulse, breakdown at timer 500, then a second pulse.
    bd_plan[0] = 500;
    bd_plan[1] = $urandom_range(50, 0);
    build(1'b0, 1'b0, 16'd100, 16'd200, 2, -1);
    run_queued();

    // Single buck pulse, breakdown at timer 400, long enough for several half-periods.
    bd_plan[0] = 400;
    build(1'b1, 1'b1, 16'd300, 16'(int'($urandom_range(100, 1))), 1, -1);
    run_queued();

    // Open-circuit timeout, then a normal pulse.
    bd_plan[0] = WAIT_TO + 1;
    bd_plan[1] = 20;
    build(1'b0, 1'b0, 16'd50, 16'd60, 2, -1);
    run_queued();

    // Breakdown on the same cycle the timeout expires.
    bd_plan[0] = WAIT_TO;
    build(1'b1, 1'b0, 16'd30, 16'd20, 1, -1);
    run_queued();

    // Enable dropped in the middle of the buck discharge.
    bd_plan[0] = 10;
    build(1'b1, 1'b0, 16'd200, 16'd50, 1, 80);
    run_queued();

    // Zero durations: each state lasts a single cycle.
    bd_plan[0] = 0;
    bd_plan[1] = 0;
    bd_plan[2] = 0;
    build(1'b0, 1'b0, 16'd0, 16'd0, 3, -1);
    run_queued();
    bd_plan[0] = 0;
    build(1'b1, 1'b1, 16'd0, 16'd0, 1, -1);
    run_queued();
    bd_plan[0] = 2;
    build(1'b1, 1'b0, 16'd5, 16'd3, 1, -1);
    run_queued();

    // Randomized pulse trains.
    for (int n = 0; n < 24; n++) begin
      bk = 1'($urandom_range(1, 0));
      sg = 1'($urandom_range(1, 0));
      np = sg ? 1 : int'($urandom_range(3, 1));
      for (int p = 0; p < np; p++) begin
        r = int'($urandom_range(99, 0));
        bd_plan[p] = (r < 80) ? int'($urandom_range(120, 0)) : (r < 90) ? WAIT_TO : WAIT_TO + 1;
      end
      onv = ($urandom_range(9, 0) == 0) ? 16'd0 : 16'($urandom_range(120, 1));
      dtv = ($urandom_range(9, 0) == 0) ? 16'd0 : 16'($urandom_range(60, 1));
      abk = ($urandom_range(4, 0) == 0) ? int'($urandom_range(int'(onv), 0)) : -1;
      build(bk, sg, onv, dtv, np, abk);
      run_queued();
    end

    // Asynchronous reset in the middle of a resistor discharge.
    bd_plan[0] = 3;
    build(1'b0, 1'b0, 16'd100, 16'd50, 1, -1);
    while (exp_q.size() > 15) begin
      void'(exp_q.pop_back());
      void'(stim_q.pop_back());
    end
    run_queued();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_pc     = 32'd0;
    bus.waveform = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    push(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, S_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, S_IDLE, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_queued();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end
endmodule
